// File: rtl/i2c_slave_mem_controller.sv
// rtl/i2c_slave_mem_controller.sv - I2C slave protocol engine bridging a byte-level front end to a strobed memory port.
module i2c_slave_mem_controller #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int          NBYTES     = 2,
    parameter int          MATCH_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       StartDet,
    input  logic       StopDet,
    input  logic       ByteValid,
    input  logic [7:0] RxByte,
    input  logic       ByteReq,
    input  logic       MasterAck,
    output logic       AckOut,
    output logic       NackOut,
    output logic [7:0] TxByte,
    output logic       TxValid,
    output logic       MemEnable,
    output logic       MemMode,
    output logic       MemRorW,
    output logic [7:0] MemBuffer,
    input  logic [7:0] MemData,
    input  logic       AddressFound,
    output logic       Busy
);
    localparam int             BCW = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] NB  = BCW'(NBYTES);
    localparam logic [3:0]     MW  = 4'(MATCH_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_DEV_ADDR, ST_MEM_ADDR, ST_MEM_STROBE,
        ST_MATCH_WAIT, ST_WRITE_DATA, ST_READ_DATA, ST_READ_CAPTURE
    } state_t;

    typedef enum logic [1:0] {OP_MATCH, OP_WRITE, OP_READ} op_t;

    state_t         state;
    op_t            op;
    logic           strobe_phase;
    logic [3:0]     wait_cnt;
    logic [BCW-1:0] byte_count;
    logic           addr_valid;

    assign Busy = (state != ST_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_IDLE;
            op           <= OP_MATCH;
            strobe_phase <= 1'b0;
            wait_cnt     <= '0;
            byte_count   <= '0;
            addr_valid   <= 1'b0;
            AckOut       <= 1'b0;
            NackOut      <= 1'b0;
            TxValid      <= 1'b0;
            TxByte       <= 8'h00;
            MemEnable    <= 1'b0;
            MemMode      <= 1'b0;
            MemRorW      <= 1'b0;
            MemBuffer    <= 8'h00;
        end else begin
            // Pulses default low; an interrupted strobe thereby always ends low.
            AckOut    <= 1'b0;
            NackOut   <= 1'b0;
            TxValid   <= 1'b0;
            MemEnable <= 1'b0;
            if (StopDet) begin
                state <= ST_IDLE;
            end else if (StartDet) begin
                state      <= ST_DEV_ADDR;
                byte_count <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_DEV_ADDR: begin
                        if (ByteValid) begin
                            if (RxByte[7:1] != DEV_ADDR || (RxByte[0] && !addr_valid)) begin
                                NackOut <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                AckOut <= 1'b1;
                                state  <= RxByte[0] ? ST_READ_DATA : ST_MEM_ADDR;
                            end
                        end
                    end
                    ST_MEM_ADDR: begin
                        if (ByteValid) begin
                            MemBuffer    <= RxByte;
                            MemMode      <= 1'b0;
                            MemRorW      <= 1'b0;
                            op           <= OP_MATCH;
                            strobe_phase <= 1'b0;
                            state        <= ST_MEM_STROBE;
                        end
                    end
                    ST_MEM_STROBE: begin
                        if (!strobe_phase) begin
                            MemEnable    <= 1'b1;
                            strobe_phase <= 1'b1;
                        end else begin
                            strobe_phase <= 1'b0;
                            case (op)
                                OP_MATCH: begin
                                    wait_cnt <= '0;
                                    state    <= ST_MATCH_WAIT;
                                end
                                OP_WRITE: begin
                                    AckOut     <= 1'b1;
                                    byte_count <= byte_count + BCW'(1);
                                    state      <= ST_WRITE_DATA;
                                end
                                default: state <= ST_READ_CAPTURE;
                            endcase
                        end
                    end
                    ST_MATCH_WAIT: begin
                        if (wait_cnt == MW) begin
                            if (AddressFound) begin
                                AckOut     <= 1'b1;
                                addr_valid <= 1'b1;
                                byte_count <= '0;
                                state      <= ST_WRITE_DATA;
                            end else begin
                                NackOut    <= 1'b1;
                                addr_valid <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    ST_WRITE_DATA: begin
                        if (ByteValid) begin
                            if (byte_count < NB) begin
                                MemBuffer    <= RxByte;
                                MemMode      <= 1'b1;
                                MemRorW      <= 1'b0;
                                op           <= OP_WRITE;
                                strobe_phase <= 1'b0;
                                state        <= ST_MEM_STROBE;
                            end else begin
                                NackOut <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                    ST_READ_DATA: begin
                        if (ByteReq) begin
                            if (!MasterAck && byte_count != '0) begin
                                state <= ST_IDLE;
                            end else if (byte_count < NB) begin
                                MemMode      <= 1'b1;
                                MemRorW      <= 1'b1;
                                op           <= OP_READ;
                                strobe_phase <= 1'b0;
                                state        <= ST_MEM_STROBE;
                            end else begin
                                // Past the location size the master just sees filler.
                                TxByte  <= 8'hFF;
                                TxValid <= 1'b1;
                            end
                        end
                    end
                    ST_READ_CAPTURE: begin
                        TxByte     <= MemData;
                        TxValid    <= 1'b1;
                        byte_count <= byte_count + BCW'(1);
                        state      <= ST_READ_DATA;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_mem_controller.sv
// tb/tb_i2c_slave_mem_controller.sv - self-checking bench for i2c_slave_mem_controller.
module tb_i2c_slave_mem_controller;
    localparam int NB = 2;
    localparam int MW = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       StartDet = 1'b0, StopDet = 1'b0, ByteValid = 1'b0, ByteReq = 1'b0, MasterAck = 1'b1;
    logic [7:0] RxByte = 8'h00;
    logic       AckOut, NackOut, TxValid, MemEnable, MemMode, MemRorW, Busy;
    logic [7:0] TxByte, MemBuffer;
    logic [7:0] MemData = 8'h00;
    logic       AddressFound = 1'b0;

    i2c_slave_mem_controller #(.DEV_ADDR(7'h50), .NBYTES(NB), .MATCH_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .StartDet(StartDet), .StopDet(StopDet),
        .ByteValid(ByteValid), .RxByte(RxByte), .ByteReq(ByteReq), .MasterAck(MasterAck),
        .AckOut(AckOut), .NackOut(NackOut), .TxByte(TxByte), .TxValid(TxValid),
        .MemEnable(MemEnable), .MemMode(MemMode), .MemRorW(MemRorW), .MemBuffer(MemBuffer),
        .MemData(MemData), .AddressFound(AddressFound), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]      dev;
        logic [7:0]      addr;
        logic [7:0]      limit;
        logic [3:0][7:0] d;
        int              n;
        int              ea, en, es, et;
    } vec_t;

    int n_checks = 0, n_pass = 0;

    // Memory device attached to the DUT plus event monitor.
    logic [7:0] dev_mem [256];
    logic [7:0] dev_ptr = 8'h00;
    logic [7:0] limit = 8'h40;
    bit         mem_init = 1'b0;
    bit         prev_en = 1'b0;
    int         ack_cnt = 0, nack_cnt = 0, both_cnt = 0, en_violate = 0;
    logic [9:0] strobe_log [$];
    logic [7:0] got_tx [$];

    always @(negedge Clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) dev_mem[i] = 8'(i) ^ 8'h5A;
            mem_init = 1'b1;
        end
        if (MemEnable) begin
            strobe_log.push_back({MemMode, MemRorW, MemBuffer});
            if (prev_en) en_violate++;
            if (!MemMode) begin
                dev_ptr      = MemBuffer;
                AddressFound = (MemBuffer < limit);
            end else if (!MemRorW) begin
                dev_mem[dev_ptr] = MemBuffer;
                dev_ptr++;
            end else begin
                MemData = dev_mem[dev_ptr];
                dev_ptr++;
            end
        end
        prev_en = MemEnable;
        if (AckOut) ack_cnt++;
        if (NackOut) nack_cnt++;
        if (AckOut && NackOut) both_cnt++;
        if (TxValid) got_tx.push_back(TxByte);
    end

    // Transaction-level reference: I2C rules applied to a plain array.
    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr = 8'h00;
    bit         ref_valid = 1'b0;
    int         rc_ack, rc_nack;
    logic [9:0] exp_strb [$];
    logic [7:0] exp_tx [$];

    function automatic void ref_txn(input vec_t v);
        rc_ack = 0; rc_nack = 0;
        exp_strb.delete(); exp_tx.delete();
        if (v.dev[7:1] != 7'h50 || (v.dev[0] && !ref_valid)) begin
            rc_nack = 1;
            return;
        end
        rc_ack = 1;
        if (v.dev[0]) begin
            for (int i = 0; i < v.n; i++) begin
                if (i < NB) begin
                    exp_strb.push_back(10'h300);
                    exp_tx.push_back(ref_mem[ref_ptr]);
                    ref_ptr++;
                end else begin
                    exp_tx.push_back(8'hFF);
                end
            end
            return;
        end
        exp_strb.push_back({2'b00, v.addr});
        ref_ptr   = v.addr;
        ref_valid = (v.addr < v.limit);
        if (!ref_valid) begin
            rc_nack = 1;
            return;
        end
        rc_ack++;
        for (int i = 0; i < v.n; i++) begin
            if (i == NB) begin
                rc_nack++;
                return;
            end
            exp_strb.push_back({2'b10, v.d[i]});
            ref_mem[ref_ptr] = v.d[i];
            ref_ptr++;
            rc_ack++;
        end
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic vec_t mk(input logic [7:0] dev, addr, lim, input int n, input logic [31:0] d,
                                input int ea, en, es, et);
        vec_t v;
        v.dev = dev; v.addr = addr; v.limit = lim; v.n = n; v.d = d;
        v.ea = ea; v.en = en; v.es = es; v.et = et;
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge Clk); StartDet = 1'b1;
        @(negedge Clk); StartDet = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic pulse_stop();
        @(negedge Clk); StopDet = 1'b1;
        @(negedge Clk); StopDet = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk); RxByte = b; ByteValid = 1'b1;
        @(negedge Clk); ByteValid = 1'b0;
        repeat (10) @(negedge Clk);
    endtask

    task automatic req_byte(input logic ack);
        @(negedge Clk); ByteReq = 1'b1; MasterAck = ack;
        @(negedge Clk); ByteReq = 1'b0; MasterAck = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag, input int ea, en, es, et);
        int a0, n0, s0, t0;
        logic [9:0] g;
        a0 = ack_cnt; n0 = nack_cnt; s0 = strobe_log.size(); t0 = got_tx.size();
        limit = v.limit;
        pulse_start();
        send_byte(v.dev);
        if (!v.dev[0]) begin
            send_byte(v.addr);
            for (int i = 0; i < v.n; i++) send_byte(v.d[i]);
        end else begin
            for (int i = 0; i < v.n; i++) req_byte(1'b1);
        end
        pulse_stop();
        check({tag, ".ack"}, ack_cnt - a0, ea);
        check({tag, ".nack"}, nack_cnt - n0, en);
        check({tag, ".strobes"}, strobe_log.size() - s0, es);
        check({tag, ".txvalid"}, got_tx.size() - t0, et);
        for (int i = 0; i < exp_strb.size() && s0 + i < strobe_log.size(); i++) begin
            g = strobe_log[s0 + i];
            if (g[8]) g[7:0] = 8'h00;
            check($sformatf("%s.strobe%0d", tag, i), g, exp_strb[i]);
        end
        for (int i = 0; i < exp_tx.size() && t0 + i < got_tx.size(); i++)
            check($sformatf("%s.txbyte%0d", tag, i), got_tx[t0 + i], exp_tx[i]);
        check({tag, ".idle"}, Busy, 1'b0);
    endtask

    vec_t tbl [9];
    vec_t rv;
    int   a0, n0, s0, t0, en_k, nack_k;
    bit   hold_ok;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        tbl[0] = mk(8'hA1, 8'h00, 8'h40, 3, 32'h0,         0, 1, 0, 0);
        tbl[1] = mk(8'hA2, 8'h00, 8'h40, 1, 32'h0,         0, 1, 0, 0);
        tbl[2] = mk(8'hA0, 8'h03, 8'h40, 2, 32'h0000_2211, 4, 0, 3, 0);
        tbl[3] = mk(8'hA1, 8'h00, 8'h40, 3, 32'h0,         1, 0, 2, 3);
        tbl[4] = mk(8'hA0, 8'h10, 8'h40, 3, 32'h0055_4433, 4, 1, 3, 0);
        tbl[5] = mk(8'hA0, 8'h07, 8'h00, 1, 32'h0000_0066, 1, 1, 1, 0);
        tbl[6] = mk(8'hA1, 8'h00, 8'h40, 2, 32'h0,         0, 1, 0, 0);
        tbl[7] = mk(8'hA0, 8'h03, 8'h40, 0, 32'h0,         2, 0, 1, 0);
        tbl[8] = mk(8'hA1, 8'h00, 8'h40, 1, 32'h0,         1, 0, 1, 1);

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset.flags", {AckOut, NackOut, TxValid, MemEnable, MemMode, MemRorW, Busy}, 7'd0);
        check("reset.txbyte", TxByte, 8'h00);
        check("reset.membuffer", MemBuffer, 8'h00);

        for (int i = 0; i < 9; i++) begin
            ref_txn(tbl[i]);
            run_txn(tbl[i], $sformatf("vec%0d", i), tbl[i].ea, tbl[i].en, tbl[i].es, tbl[i].et);
        end

        // Failed address match: strobe timing, buffer hold and NACK latency.
        limit = 8'h00;
        a0 = ack_cnt; s0 = strobe_log.size();
        pulse_start();
        send_byte(8'hA0);
        @(negedge Clk); RxByte = 8'h07; ByteValid = 1'b1;
        @(negedge Clk); ByteValid = 1'b0;
        en_k = -1; nack_k = -1; hold_ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge Clk);
            if (MemEnable && en_k < 0) en_k = k;
            if (NackOut && nack_k < 0) nack_k = k;
            if (k <= 2 && (MemBuffer !== 8'h07 || MemMode !== 1'b0)) hold_ok = 1'b0;
        end
        check("match.enable_cycle", en_k, 1);
        check("match.nack_latency", nack_k, 2 + MW + 1);
        check("match.buffer_hold", hold_ok, 1'b1);
        check("match.strobes", strobe_log.size() - s0, 1);
        check("match.acks", ack_cnt - a0, 1);
        pulse_stop();

        // Stop coincident with a write byte.
        limit = 8'h80;
        pulse_start();
        send_byte(8'hA0);
        send_byte(8'h05);
        a0 = ack_cnt; s0 = strobe_log.size();
        @(negedge Clk); RxByte = 8'h99; ByteValid = 1'b1; StopDet = 1'b1;
        @(negedge Clk); ByteValid = 1'b0; StopDet = 1'b0;
        repeat (10) @(negedge Clk);
        check("stopwr.strobes", strobe_log.size() - s0, 0);
        check("stopwr.acks", ack_cnt - a0, 0);
        check("stopwr.busy", Busy, 1'b0);

        // Master NACK after the first read byte ends the transfer.
        a0 = ack_cnt; s0 = strobe_log.size(); t0 = got_tx.size();
        pulse_start();
        send_byte(8'hA1);
        req_byte(1'b1);
        req_byte(1'b0);
        check("mnack.acks", ack_cnt - a0, 1);
        check("mnack.strobes", strobe_log.size() - s0, 1);
        check("mnack.txvalid", got_tx.size() - t0, 1);
        if (got_tx.size() > t0) check("mnack.txbyte", got_tx[t0], 8'h5F);
        check("mnack.busy", Busy, 1'b0);
        pulse_stop();

        // Reset while MemEnable is high.
        a0 = ack_cnt; n0 = nack_cnt; s0 = strobe_log.size();
        pulse_start();
        send_byte(8'hA0);
        @(negedge Clk); RxByte = 8'h05; ByteValid = 1'b1;
        @(negedge Clk); ByteValid = 1'b0;
        @(negedge Clk);
        check("rststrobe.enable_high", MemEnable, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        ref_valid = 1'b0;
        check("rststrobe.enable_low", MemEnable, 1'b0);
        check("rststrobe.membuffer", MemBuffer, 8'h00);
        repeat (10) @(negedge Clk);
        check("rststrobe.strobes", strobe_log.size() - s0, 1);
        check("rststrobe.acknack", {ack_cnt - a0, nack_cnt - n0}, 64'd1 << 32);
        check("rststrobe.busy", Busy, 1'b0);

        do_reset();
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0, 1: rv.dev = 8'hA0;
                2:    rv.dev = 8'hA1;
                default: begin
                    rv.dev = 8'($urandom_range(0, 255));
                    if (rv.dev[7:1] == 7'h50) rv.dev[7:1] = 7'h51;
                end
            endcase
            rv.addr  = 8'($urandom_range(0, 255));
            rv.limit = 8'h80;
            rv.n     = $urandom_range(0, 4);
            rv.d     = $urandom;
            ref_txn(rv);
            run_txn(rv, $sformatf("rnd%0d", t), rc_ack, rc_nack, exp_strb.size(), exp_tx.size());
        end

        check("ack_nack_overlap", both_cnt, 0);
        check("enable_multi_cycle", en_violate, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
